esn_reservoir_seq: RTL

//  Parametrised, time-multiplexed echo-state reservoir. Computes x[n+1] = f(W*x[n] + Win*u[n])

---
 rtl/esn_reservoir_seq_pkg.sv | 13 +
 rtl/esn_reservoir_seq_wcol_ram.sv | 23 ++
 rtl/esn_reservoir_seq.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/esn_reservoir_seq_pkg.sv
// Shared types and constants for the time-multiplexed echo-state reservoir.
package esn_reservoir_seq_pkg;

  localparam int LEAK_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_UPDATE
  } state_e;

endpackage

// File: rtl/esn_reservoir_seq_wcol_ram.sv
// Simple dual-port weight column RAM: one full column per word, registered read, no reset.
module esn_reservoir_seq_wcol_ram #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 9,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/esn_reservoir_seq.sv
// Echo-state reservoir: NEUR parallel MAC lanes walk the weight columns one per cycle,
// then saturate (and optionally leak) the sums into the state register.
module esn_reservoir_seq
  import esn_reservoir_seq_pkg::*;
#(
  parameter  int DW      = 16,
  parameter  int FRAC    = 12,
  parameter  int NEUR    = 8,
  parameter  int LEAK_EN = 0,
  localparam int AW      = $clog2(NEUR + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               u_valid,
  output logic               u_ready,
  input  logic [DW-1:0]      u_data,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [NEUR*DW-1:0] wr_data,
  output logic               wr_err,
  input  logic [LEAK_W-1:0]  leak_shift,
  input  logic               clear_state,
  output logic [NEUR*DW-1:0] xstate,
  output logic               x_valid
);

  localparam int ACCW = 2*DW + AW;
  localparam logic signed [ACCW-1:0] ACC_MAX  = ACCW'(2**(DW-1) - 1);
  localparam logic signed [ACCW-1:0] ACC_MIN  = ~ACC_MAX;
  localparam logic signed [DW+1:0]   WIDE_MAX = (DW+2)'(2**(DW-1) - 1);
  localparam logic signed [DW+1:0]   WIDE_MIN = ~WIDE_MAX;

  function automatic logic signed [DW-1:0] sat_acc(input logic signed [ACCW-1:0] a);
    logic signed [ACCW-1:0] s;
    s = a >>> FRAC;
    if (s > ACC_MAX) return ACC_MAX[DW-1:0];
    if (s < ACC_MIN) return ACC_MIN[DW-1:0];
    return s[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] sat_wide(input logic signed [DW+1:0] v);
    if (v > WIDE_MAX) return WIDE_MAX[DW-1:0];
    if (v < WIDE_MIN) return WIDE_MIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  function automatic logic signed [DW-1:0] leak_step(input logic signed [DW-1:0] x,
                                                     input logic signed [DW-1:0] y,
                                                     input logic [LEAK_W-1:0]    sh);
    logic signed [DW:0]   diff;
    logic signed [DW:0]   term_w;
    logic signed [DW-1:0] term;
    logic signed [DW+1:0] sum;
    diff   = {y[DW-1], y} - {x[DW-1], x};
    term_w = diff >>> sh;
    term   = sat_wide({term_w[DW], term_w});
    sum    = {{2{x[DW-1]}}, x} + {{2{term[DW-1]}}, term};
    return sat_wide(sum);
  endfunction

  state_e                 state_q, state_d;
  logic [AW-1:0]          col_q, col_d;
  logic [AW-1:0]          col_p1_q, col_p1_d;
  logic                   mac_vld_p1_q, mac_vld_p1_d;
  logic                   upd_vld_p2_q, upd_vld_p2_d;
  logic                   x_valid_q, x_valid_d;
  logic                   wr_err_q, wr_err_d;
  logic signed [DW-1:0]   u_q, u_d;
  logic [LEAK_W-1:0]      leak_q, leak_d;
  logic signed [ACCW-1:0] acc_q [NEUR];
  logic signed [ACCW-1:0] acc_d [NEUR];
  logic signed [DW-1:0]   x_q [NEUR];
  logic signed [DW-1:0]   x_d [NEUR];

  logic                   hs, wr_ok, rd_en;
  logic [NEUR*DW-1:0]     rd_data;
  logic signed [DW-1:0]   operand;
  logic signed [DW-1:0]   w_lane [NEUR];
  logic signed [2*DW-1:0] prod [NEUR];
  logic signed [DW-1:0]   y_lane [NEUR];

  assign u_ready = !rst && (state_q == S_IDLE);
  assign hs      = u_valid && u_ready;
  assign wr_ok   = wr_en && !rst && (state_q == S_IDLE) && (wr_addr <= AW'(NEUR));
  assign wr_err  = wr_err_q;
  assign x_valid = x_valid_q;

  esn_reservoir_seq_wcol_ram #(
    .WIDTH(NEUR*DW),
    .DEPTH(NEUR+1),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re   (rd_en),
    .raddr(col_q),
    .rdata(rd_data)
  );

  // p1: RAM word for column col_p1_q is on rd_data. The state register is frozen
  // while a sample is in flight, so it serves directly as the snapshot operand.
  always_comb begin
    operand = u_q;
    for (int j = 0; j < NEUR; j++)
      if (col_p1_q == AW'(j)) operand = x_q[j];
  end

  for (genvar g = 0; g < NEUR; g++) begin : g_lane
    assign w_lane[g]            = rd_data[g*DW +: DW];
    assign prod[g]              = w_lane[g] * operand;
    assign y_lane[g]            = sat_acc(acc_q[g]);
    assign xstate[g*DW +: DW]   = x_q[g];
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    col_p1_d     = col_q;
    u_d          = u_q;
    leak_d       = leak_q;
    mac_vld_p1_d = 1'b0;
    upd_vld_p2_d = 1'b0;
    x_valid_d    = upd_vld_p2_q;
    wr_err_d     = wr_en && !wr_ok;
    rd_en        = 1'b0;
    acc_d        = acc_q;
    x_d          = x_q;
    if (mac_vld_p1_q)
      for (int i = 0; i < NEUR; i++) acc_d[i] = acc_q[i] + ACCW'(prod[i]);
    unique case (state_q)
      S_IDLE: begin
        if (clear_state)
          for (int i = 0; i < NEUR; i++) x_d[i] = '0;
        if (hs) begin
          u_d     = u_data;
          leak_d  = leak_shift;
          col_d   = '0;
          state_d = S_ACCUM;
          for (int i = 0; i < NEUR; i++) acc_d[i] = '0;
        end
      end
      S_ACCUM: begin
        rd_en        = 1'b1;
        mac_vld_p1_d = 1'b1;
        if (col_q == AW'(NEUR)) state_d = S_DRAIN;
        else                    col_d   = col_q + 1'b1;
      end
      S_DRAIN: state_d = S_UPDATE;
      // p2: accumulators complete; activation and leak land in the state register.
      S_UPDATE: begin
        for (int i = 0; i < NEUR; i++)
          x_d[i] = (LEAK_EN != 0) ? leak_step(x_q[i], y_lane[i], leak_q) : y_lane[i];
        upd_vld_p2_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      col_p1_q     <= '0;
      mac_vld_p1_q <= 1'b0;
      upd_vld_p2_q <= 1'b0;
      x_valid_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      u_q          <= '0;
      leak_q       <= '0;
      for (int i = 0; i < NEUR; i++) begin
        acc_q[i] <= '0;
        x_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      col_p1_q     <= col_p1_d;
      mac_vld_p1_q <= mac_vld_p1_d;
      upd_vld_p2_q <= upd_vld_p2_d;
      x_valid_q    <= x_valid_d;
      wr_err_q     <= wr_err_d;
      u_q          <= u_d;
      leak_q       <= leak_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
    end
  end

endmodule
